// File: rtl/bpred_resolve_queue.sv
// In-order branch resolve queue between fetch and execute: updates the predictor
// on resolve and flushes wrong-path entries on a mispredict. Optional counters: BPRED_STATS_EN.
module bpred_resolve_queue #(
  parameter int PCWIDTH   = 32,
  parameter int DEPTH     = 8,
  parameter int LOG2DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 push,
  input  logic [PCWIDTH-1:0]   push_pc,
  input  logic                 push_pred,
  input  logic                 resolve_valid,
  input  logic                 resolve_taken,
  input  logic [PCWIDTH-1:0]   resolve_target,
  output logic                 result_rdy,
  output logic                 result,
  output logic [PCWIDTH-1:0]   pc_result,
  output logic                 mispredict,
  output logic [PCWIDTH-1:0]   redirect_pc,
  output logic                 full,
  output logic                 empty,
  output logic [LOG2DEPTH:0]   count,
  output logic                 err_overflow,
  output logic                 err_underflow,
  output logic [31:0]          stat_branches,
  output logic [31:0]          stat_mispredicts
);

  typedef struct packed {
    logic [PCWIDTH-1:0] pc;
    logic               pred;
  } entry_t;

  entry_t                 mem_q [DEPTH];
  entry_t                 head;

  logic [LOG2DEPTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LOG2DEPTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LOG2DEPTH:0]     count_q, count_d;

  logic                   result_rdy_q;
  logic                   result_q;
  logic [PCWIDTH-1:0]     pc_result_q;
  logic                   mispredict_q;
  logic [PCWIDTH-1:0]     redirect_pc_q;
  logic                   err_overflow_q;
  logic                   err_underflow_q;

  logic                   resolve_acc;
  logic                   push_acc;
  logic                   flush_now;
  logic [PCWIDTH-1:0]     redirect_d;

  assign full  = (count_q == (LOG2DEPTH+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Resolvability uses the occupancy at the start of the cycle, so a
  // same-cycle push never makes an empty queue resolvable.
  assign resolve_acc = resolve_valid && !empty;
  assign flush_now   = resolve_acc && (resolve_taken != head.pred);
  assign push_acc    = push && !full && !mispredict_q && !flush_now;
  assign redirect_d  = resolve_taken ? resolve_target : (head.pc + PCWIDTH'(4));

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_now) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_acc)    wr_ptr_d = wr_ptr_q + 1'b1;
      if (resolve_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_acc, resolve_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= '{pc: push_pc, pred: push_pred};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      result_rdy_q    <= 1'b0;
      result_q        <= 1'b0;
      pc_result_q     <= '0;
      mispredict_q    <= 1'b0;
      redirect_pc_q   <= '0;
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      result_rdy_q <= resolve_acc;
      mispredict_q <= flush_now;
      if (resolve_acc) begin
        result_q    <= resolve_taken;
        pc_result_q <= head.pc;
      end
      if (flush_now) redirect_pc_q <= redirect_d;
      // A full-queue push that a flush would discard anyway is not an overflow.
      if (push && full && !flush_now && !mispredict_q) err_overflow_q <= 1'b1;
      if (resolve_valid && empty) err_underflow_q <= 1'b1;
    end
  end

  assign result_rdy    = result_rdy_q;
  assign result        = result_q;
  assign pc_result     = pc_result_q;
  assign mispredict    = mispredict_q;
  assign redirect_pc   = redirect_pc_q;
  assign err_overflow  = err_overflow_q;
  assign err_underflow = err_underflow_q;

`ifdef BPRED_STATS_EN
  logic [31:0] stat_br_q;
  logic [31:0] stat_mp_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      if (resolve_acc && (stat_br_q != '1)) stat_br_q <= stat_br_q + 32'd1;
      if (flush_now && (stat_mp_q != '1))   stat_mp_q <= stat_mp_q + 32'd1;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_bpred_resolve_queue.sv
// Scoreboard bench for bpred_resolve_queue: queue-based reference model, directed
// scenarios followed by randomized traffic with an asynchronous reset in the middle.
module tb_bpred_resolve_queue;

  localparam int PW = 32;
  localparam int D  = 8;
  localparam int LD = 3;

  logic          clk = 1'b0;
  logic          resetn;
  logic          push;
  logic [PW-1:0] push_pc;
  logic          push_pred;
  logic          resolve_valid;
  logic          resolve_taken;
  logic [PW-1:0] resolve_target;
  logic          result_rdy;
  logic          result;
  logic [PW-1:0] pc_result;
  logic          mispredict;
  logic [PW-1:0] redirect_pc;
  logic          full;
  logic          empty;
  logic [LD:0]   count;
  logic          err_overflow;
  logic          err_underflow;
  logic [31:0]   stat_branches;
  logic [31:0]   stat_mispredicts;

  always #5 clk = ~clk;

  bpred_resolve_queue #(.PCWIDTH(PW), .DEPTH(D), .LOG2DEPTH(LD)) dut (
    .clk(clk), .resetn(resetn),
    .push(push), .push_pc(push_pc), .push_pred(push_pred),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .resolve_target(resolve_target),
    .result_rdy(result_rdy), .result(result), .pc_result(pc_result),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .full(full), .empty(empty), .count(count),
    .err_overflow(err_overflow), .err_underflow(err_underflow),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  typedef struct { logic [31:0] pc; logic pred; } ment_t;
  typedef struct {
    int          due;
    logic        taken;
    logic [31:0] pc;
    logic        mis;
    logic [31:0] redir;
  } exp_t;

  ment_t mq[$];
  exp_t  eq[$];

  logic        m_mis, m_of, m_uf;
  logic [31:0] m_sb, m_sm;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;

  always @(posedge clk) cyc++;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    eq.delete();
    m_mis = 1'b0; m_of = 1'b0; m_uf = 1'b0;
    m_sb = '0;    m_sm = '0;
  endfunction

  function automatic void check_zero(string tag);
    chk({tag, "_result_rdy"},  32'(result_rdy), 0);
    chk({tag, "_result"},      32'(result), 0);
    chk({tag, "_pc_result"},   pc_result, 0);
    chk({tag, "_mispredict"},  32'(mispredict), 0);
    chk({tag, "_redirect_pc"}, redirect_pc, 0);
    chk({tag, "_count"},       32'(count), 0);
    chk({tag, "_empty"},       32'(empty), 1);
    chk({tag, "_err_of"},      32'(err_overflow), 0);
    chk({tag, "_err_uf"},      32'(err_underflow), 0);
    chk({tag, "_stat_br"},     stat_branches, 0);
    chk({tag, "_stat_mp"},     stat_mispredicts, 0);
  endfunction

  // Called at a negedge: check state left by the last edge, apply inputs,
  // advance the model by one cycle, then wait for the next negedge.
  task automatic step(input logic p, input logic [31:0] pc, input logic pr,
                      input logic rv, input logic rt, input logic [31:0] tg);
    logic racc, flush, pacc, fl;
    ment_t h;
    chk("count", 32'(count), 32'(mq.size()));
    chk("full",  32'(full),  32'(mq.size() == D));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("err_overflow",  32'(err_overflow),  32'(m_of));
    chk("err_underflow", 32'(err_underflow), 32'(m_uf));
`ifdef BPRED_STATS_EN
    chk("stat_branches",    stat_branches,    m_sb);
    chk("stat_mispredicts", stat_mispredicts, m_sm);
`else
    chk("stat_branches_off",    stat_branches,    0);
    chk("stat_mispredicts_off", stat_mispredicts, 0);
`endif
    push = p; push_pc = pc; push_pred = pr;
    resolve_valid = rv; resolve_taken = rt; resolve_target = tg;

    fl    = (mq.size() == D);
    racc  = rv && (mq.size() != 0);
    flush = 1'b0;
    if (rv && mq.size() == 0) m_uf = 1'b1;
    if (racc) begin
      h     = mq.pop_front();
      flush = (rt != h.pred);
      eq.push_back('{due: cyc + 1, taken: rt, pc: h.pc, mis: flush,
                     redir: rt ? tg : h.pc + 32'd4});
      if (m_sb != 32'hFFFF_FFFF) m_sb++;
      if (flush && m_sm != 32'hFFFF_FFFF) m_sm++;
    end
    pacc = p && !fl && !m_mis && !flush;
    if (p && fl && !m_mis && !flush) m_of = 1'b1;
    if (flush) mq.delete();
    else if (pacc) mq.push_back('{pc: pc, pred: pr});
    m_mis = flush;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic async_reset();
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    check_zero("async_rst");
    @(negedge clk);
    push = 1'b0; resolve_valid = 1'b0;
    resetn = 1'b1;
  endtask

  // Monitor: every predictor-update cycle is matched against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (resetn) begin
        if (eq.size() != 0 && eq[0].due < cyc) begin
          e = eq.pop_front();
          chk("missing_result_rdy", 32'(result_rdy), 1);
        end
        if (result_rdy) begin
          if (eq.size() == 0) begin
            chk("spurious_result_rdy", 32'(result_rdy), 0);
          end else begin
            e = eq.pop_front();
            chk("result_latency", cyc, e.due);
            chk("result",         32'(result), 32'(e.taken));
            chk("pc_result",      pc_result, e.pc);
            chk("mispredict",     32'(mispredict), 32'(e.mis));
            if (e.mis) chk("redirect_pc", redirect_pc, e.redir);
          end
        end else if (mispredict) begin
          chk("stray_mispredict", 32'(mispredict), 0);
        end
      end
    end
  end

  initial begin
    logic        p, pr, rv, rt;
    logic [31:0] pc, tg;
    resetn = 1'b0;
    push = 1'b0; push_pc = '0; push_pred = 1'b0;
    resolve_valid = 1'b0; resolve_taken = 1'b0; resolve_target = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("reset");
    resetn = 1'b1;

    // Correctly predicted taken branch
    step(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h0);
    idle(); idle();

    // Predicted not-taken, actually taken
    step(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h480);
    idle(); idle();

    // Flush of younger entries; pushes in resolve and mispredict cycles dropped
    step(1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h14, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h18, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h50, 1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 32'h60, 1'b1, 1'b0, 1'b0, 32'h0);
    idle(); idle();

    // Overflow and pointer wrap-around
    for (int i = 0; i < 9; i++) step(1'b1, 32'h1000 + 32'(4 * i), 1'b1, 1'b0, 1'b0, 32'h0);
    idle();
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0);
    idle(); idle();

    // Underflow with simultaneous push
    step(1'b1, 32'h300, 1'b1, 1'b1, 1'b0, 32'h0);
    idle();
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0);
    idle(); idle();

    // Five resolves, two mispredicting, then asynchronous reset
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'h2000 + 32'(16 * i), 1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b0, 32'h0, 1'b0, 1'b1, (i >= 2), 32'h3000 + 32'(i));
      idle();
    end
    idle();
    step(1'b1, 32'h4000, 1'b0, 1'b0, 1'b0, 32'h0);
    async_reset();

    for (int i = 0; i < 1500; i++) begin
      p  = ($urandom_range(0, 99) < 55);
      pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      pr = 1'($urandom_range(0, 1));
      rv = ($urandom_range(0, 99) < 45);
      tg = $urandom;
      if (mq.size() != 0 && $urandom_range(0, 3) != 0) rt = mq[0].pred;
      else rt = 1'($urandom_range(0, 1));
      if (i < 40) pc = 32'hFFFF_FFFC;
      step(p, pc, pr, rv, rt, tg);
      if (i == 700) async_reset();
    end
    idle(); idle();
    chk("scoreboard_drained", 32'(eq.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bpred_resolve_queue.md
Name: bpred_resolve_queue

Overview:
- In-order queue between fetch and execute that tracks every branch for which branchpredict issued a prediction.
- Holds the branch PC and the predicted direction until execute resolves the oldest branch.
- On resolution, drives branchpredict's result port (result_rdy / result / pc_result).
- On a wrong prediction, raises a one-cycle mispredict with a redirect PC and flushes all younger (wrong-path) entries.

Parameters:
- PCWIDTH, 32, width of all PC values
- DEPTH, 8, maximum in-flight branches (power of 2)
- LOG2DEPTH, 3, log2(DEPTH); width of the read/write pointers

Ports:
- clk  input  1  system clock, all state on posedge
- resetn  input  1  asynchronous active-low reset
- push  input  1  fetch issued a prediction for a branch this cycle
- push_pc  input  PCWIDTH  PC of that branch
- push_pred  input  1  prediction from branchpredict (1 = taken)
- resolve_valid  input  1  execute resolved the oldest outstanding branch
- resolve_taken  input  1  actual direction (1 = taken)
- resolve_target  input  PCWIDTH  actual taken target
- result_rdy  output  1  to branchpredict: write strobe
- result  output  1  to branchpredict: actual direction
- pc_result  output  PCWIDTH  to branchpredict: PC being updated
- mispredict  output  1  one-cycle flush/redirect pulse
- redirect_pc  output  PCWIDTH  correct next PC, valid while mispredict = 1
- full  output  1  count == DEPTH (combinational from count)
- empty  output  1  count == 0 (combinational from count)
- count  output  LOG2DEPTH+1  number of occupied entries
- err_overflow  output  1  sticky: push dropped because queue was full
- err_underflow  output  1  sticky: resolve_valid seen while queue was empty
- stat_branches  output  32  resolved-branch counter (optional feature)
- stat_mispredicts  output  32  mispredict counter (optional feature)

Behaviour:
- Reset (resetn low, asynchronous): rd_ptr = wr_ptr = count = 0. All registered outputs go to 0: result_rdy, result, pc_result, mispredict, redirect_pc, err_*, stat_*. Entry storage is not reset.
- Storage: circular buffer of {pc, pred}. Pointers wrap DEPTH-1 -> 0 naturally by LOG2DEPTH-bit overflow.
- Push accepted when push && !full && !mispredict && !flush_now. Accepted push writes entry[wr_ptr] and increments wr_ptr.
- Push while full: dropped, err_overflow set (no other state change). Pushes dropped by a flush do not set the error.
- Resolve accepted when resolve_valid && !empty, using the count at the start of the cycle. Reads entry[rd_ptr] and increments rd_ptr.
  - A push in the same cycle does not make an empty queue resolvable.
- resolve_valid while empty: ignored, err_underflow set.
- Result port (registered, 1-cycle latency): the cycle after an accepted resolve, result_rdy = 1, result = resolve_taken, pc_result = entry.pc. Otherwise result_rdy = 0 and result / pc_result hold their last values.
- flush_now = accepted resolve && (resolve_taken != entry.pred). At that clock edge:
  - rd_ptr = wr_ptr = count = 0; any same-cycle push is discarded.
  - Next cycle mispredict = 1 for exactly one cycle.
  - redirect_pc = resolve_target if taken, else entry.pc + 4 (modulo 2^PCWIDTH).
  - Pushes are also discarded during the mispredict cycle (wrong path still in flight).
- Correct prediction: no flush; count += push_acc - resolve_acc. Simultaneous push and resolve at full is not possible, because push is gated by full.
- Error flags clear only on reset.
- A branch's predictor update and its mispredict pulse occur in the same cycle.

Optional Feature:
- Macro: BPRED_STATS_EN
- Defined:
  - stat_branches increments on every accepted resolve.
  - stat_mispredicts increments on every flush_now.
  - Both counters are 32-bit, saturate at 0xFFFFFFFF, and reset to 0.
- Undefined: no counter logic; both ports tied to 0. Port list is identical in both builds.

Test Plan:
1. Reset, then push pc=0x100 pred=1, next cycle resolve taken=1 -> one cycle later result_rdy=1, result=1, pc_result=0x100, mispredict=0, count returns to 0.
2. Push pc=0x200 pred=0, resolve taken=1 target=0x480 -> next cycle mispredict=1, redirect_pc=0x480, pc_result=0x200, result=1; mispredict low the following cycle.
3. Push 0x10, 0x14, 0x18 (pred=1 each); resolve 0x10 with taken=0 -> redirect_pc=0x14, count=0, empty=1; a push issued in the resolve cycle and in the mispredict cycle is not enqueued.
4. Push 9 branches back-to-back with DEPTH=8 -> full=1 after 8; 9th dropped; err_overflow=1; then 8 correct resolves return pc_result in push order with pointer wrap-around.
5. resolve_valid on an empty queue with a simultaneous push pc=0x300 -> err_underflow=1, no result_rdy, count=1, entry 0x300 intact.
6. With BPRED_STATS_EN: 5 resolves, 2 mispredicting -> stat_branches=5, stat_mispredicts=2. Assert resetn mid-sequence -> all outputs 0 immediately (asynchronously).
